// File: rtl/layer2_mem_scheduler.sv
// Layer-2 result memory sequencer: raster-order write of a WIDTH x WIDTH frame, then replay
// as KxK stride-1 conv windows to layer 3 under a valid/ready handshake.
module layer2_mem_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              save_enable,
  output logic [ADDR_W-1:0] save_row_addr,
  output logic [ADDR_W-1:0] save_col_addr,
  output logic              read_signal,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        rd_tap,
  output logic              rd_win_last,
  output logic              rd_frame_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wr_r_q, wr_r_d, wr_c_q, wr_c_d;
  logic [CW-1:0] win_r_q, win_r_d, win_c_q, win_c_d;
  logic [CW-1:0] kr_q, kr_d, kc_q, kc_d;

  logic kc_last, kr_last, winc_last, winr_last;

  assign kc_last   = (kc_q == CW'(K - 1));
  assign kr_last   = (kr_q == CW'(K - 1));
  assign winc_last = (win_c_q == CW'(WIDTH - K));
  assign winr_last = (win_r_q == CW'(WIDTH - K));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wr_r_q  <= '0;
      wr_c_q  <= '0;
      win_r_q <= '0;
      win_c_q <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_r_q  <= wr_r_d;
      wr_c_q  <= wr_c_d;
      win_r_q <= win_r_d;
      win_c_q <= win_c_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_r_d        = wr_r_q;
    wr_c_d        = wr_c_q;
    win_r_d       = win_r_q;
    win_c_d       = win_c_q;
    kr_d          = kr_q;
    kc_d          = kc_q;
    in_ready      = 1'b0;
    save_enable   = 1'b0;
    save_row_addr = '0;
    save_col_addr = '0;
    read_signal   = 1'b0;
    read_row_addr = '0;
    read_col_addr = '0;
    rd_valid      = 1'b0;
    rd_tap        = '0;
    rd_win_last   = 1'b0;
    rd_frame_last = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          wr_r_d  = '0;
          wr_c_d  = '0;
        end
      end
      StWrite: begin
        in_ready    = 1'b1;
        save_enable = in_valid;
        if (in_valid) begin
          save_row_addr = ADDR_W'(wr_r_q);
          save_col_addr = ADDR_W'(wr_c_q);
          if (wr_c_q != CW'(WIDTH - 1)) begin
            wr_c_d = wr_c_q + CW'(1);
          end else begin
            wr_c_d = '0;
            if (wr_r_q != CW'(WIDTH - 1)) begin
              wr_r_d = wr_r_q + CW'(1);
            end else begin
              wr_r_d  = '0;
              state_d = StRead;
              win_r_d = '0;
              win_c_d = '0;
              kr_d    = '0;
              kc_d    = '0;
            end
          end
        end
      end
      StRead: begin
        read_signal   = 1'b1;
        rd_valid      = 1'b1;
        read_row_addr = ADDR_W'(win_r_q) + ADDR_W'(kr_q);
        read_col_addr = ADDR_W'(win_c_q) + ADDR_W'(kc_q);
        rd_tap        = 8'(kr_q * K + kc_q);
        rd_win_last   = kr_last && kc_last;
        rd_frame_last = kr_last && kc_last && winc_last && winr_last;
        // Nested odometer: kc fastest, then kr, win_c, win_r.
        if (rd_ready) begin
          if (!kc_last) begin
            kc_d = kc_q + CW'(1);
          end else begin
            kc_d = '0;
            if (!kr_last) begin
              kr_d = kr_q + CW'(1);
            end else begin
              kr_d = '0;
              if (!winc_last) begin
                win_c_d = win_c_q + CW'(1);
              end else begin
                win_c_d = '0;
                if (!winr_last) begin
                  win_r_d = win_r_q + CW'(1);
                end else begin
                  win_r_d = '0;
                  state_d = StDone;
                end
              end
            end
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_layer2_mem_scheduler.sv
// Randomized self-checking bench for layer2_mem_scheduler (WIDTH=4, K=3) against a
// loop-built model of the write raster and the window/tap replay order.
module tb_layer2_mem_scheduler;

  localparam int W  = 4;
  localparam int KK = 3;
  localparam int AW = 16;
  localparam int NWIN = (W - KK + 1) * (W - KK + 1);
  localparam int NTAP = NWIN * KK * KK;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          save_enable;
  logic [AW-1:0] save_row_addr, save_col_addr;
  logic          read_signal;
  logic [AW-1:0] read_row_addr, read_col_addr;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [7:0]    rd_tap;
  logic          rd_win_last, rd_frame_last, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int r;
    int c;
    int tap;
    bit wl;
    bit fl;
  } tap_t;
  tap_t exp_q[$];

  layer2_mem_scheduler #(.WIDTH(W), .K(KK), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .save_enable   (save_enable),
    .save_row_addr (save_row_addr),
    .save_col_addr (save_col_addr),
    .read_signal   (read_signal),
    .read_row_addr (read_row_addr),
    .read_col_addr (read_col_addr),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_tap        (rd_tap),
    .rd_win_last   (rd_win_last),
    .rd_frame_last (rd_frame_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, |{in_ready, save_enable, save_row_addr, save_col_addr, read_signal,
                 read_row_addr, read_col_addr, rd_valid, rd_tap, rd_win_last,
                 rd_frame_last, busy, done}, 0);
  endtask

  // gap: in_valid only every 3rd cycle; rnd: random rd_ready; abort_at >= 0: reset at that tap.
  task automatic run_frame(input bit gap, input bit rnd, input int abort_at,
                           input bit hold_start, input bit skip_start);
    int n;
    int cyc;
    int idx;
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
      #1;
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
    end
    n = 0;
    cyc = 0;
    while (n < W * W && cyc < 200) begin
      @(negedge clk);
      start    = hold_start;
      in_valid = gap ? ((cyc % 3) == 0) : 1'b1;
      rd_ready = $urandom_range(0, 1);
      #1;
      check("wr_in_ready", in_ready, 1);
      check("wr_save_en", save_enable, in_valid);
      check("wr_rd_valid", rd_valid, 0);
      if (in_valid) begin
        check("wr_row", save_row_addr, n / W);
        check("wr_col", save_col_addr, n % W);
        n++;
      end else begin
        check("wr_addr_zero", {save_row_addr, save_col_addr}, 0);
      end
      cyc++;
    end
    check("wr_count", n, W * W);
    idx = 0;
    cyc = 0;
    while (idx < NTAP && cyc < 1000) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1);
      rd_ready = rnd ? $urandom_range(0, 1) : 1'b1;
      if (idx == abort_at) begin
        rst = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      #1;
      check("rd_valid", rd_valid, 1);
      check("rd_signal", read_signal, 1);
      check("rd_in_ready", in_ready, 0);
      check("rd_save_en", save_enable, 0);
      check("rd_row", read_row_addr, exp_q[idx].r);
      check("rd_col", read_col_addr, exp_q[idx].c);
      check("rd_tap", rd_tap, exp_q[idx].tap);
      check("rd_win_last", rd_win_last, exp_q[idx].wl);
      check("rd_frame_last", rd_frame_last, exp_q[idx].fl);
      if (rd_ready) idx++;
      cyc++;
    end
    check("rd_count", idx, NTAP);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_rd_valid", rd_valid, 0);
    @(negedge clk);
    #1;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_in_ready", in_ready, 0);
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    for (int wr = 0; wr <= W - KK; wr++)
      for (int wc = 0; wc <= W - KK; wc++)
        for (int kr = 0; kr < KK; kr++)
          for (int kc = 0; kc < KK; kc++) begin
            tap_t t;
            t.r   = wr + kr;
            t.c   = wc + kc;
            t.tap = kr * KK + kc;
            t.wl  = (kr == KK - 1) && (kc == KK - 1);
            t.fl  = t.wl && (wr == W - KK) && (wc == W - KK);
            exp_q.push_back(t);
          end

    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("after_release");

    run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, -1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, -1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 20, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, -1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, -1, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    check("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
